// File: rtl/display_codes_pkg.sv
// Shared digit-code constants and FSM states for the value formatter and the
// seven-segment display driver.
package display_codes_pkg;
   localparam int          DIGIT_W     = 6;
   localparam logic [5:0]  CODE_BLANK  = 6'd16;
   localparam logic [5:0]  CODE_DASH   = 6'd17;
   localparam logic [15:0] DEC_MAX_POS = 16'd9999;
   localparam logic [15:0] DEC_MAX_NEG = 16'd999;
   localparam int          SHIFT_ITERS = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PREP   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_FORMAT = 2'd3
   } fsm_state_t;
endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the BCD and binary registers left together by one bit.
module bcd_shift_step (
   input  logic [15:0] bcd_in,
   input  logic [13:0] bin_in,
   output logic [15:0] bcd_out,
   output logic [13:0] bin_out
);
   logic [15:0] adj;

   always_comb begin
      adj = bcd_in;
      for (int i = 0; i < 4; i++) begin
         if (bcd_in[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
      bcd_out = {adj[14:0], bin_in[13]};
      bin_out = {bin_in[12:0], 1'b0};
   end
endmodule

// File: rtl/display_value_formatter.sv
// Converts a 16-bit value into four display digit codes (signed/unsigned
// decimal via iterative double-dabble, or raw hex) with atomic output update.
module display_value_formatter
   import display_codes_pkg::*;
#(
   parameter logic BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        hex_mode,
   input  logic        is_signed,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic [5:0]  num0,
   output logic [5:0]  num1,
   output logic [5:0]  num2,
   output logic [5:0]  num3,
   output logic [1:0]  fsm_state
);
   // Handshake: load is accepted only on an edge where the FSM is idle; busy is
   // high from that edge until the edge that writes num*, which also raises
   // done for exactly one cycle. A load while busy is dropped, not queued.
   fsm_state_t  state, state_nxt;
   logic [15:0] val_r, bcd_r, bcd_step, mag_c;
   logic [13:0] bin_r, bin_step;
   logic [3:0]  iter_r;
   logic        hex_r, sgn_r, neg_r, ovf_r, neg_c, ovf_c, lead;
   logic [3:0]  dig;
   logic [5:0]  code [4];

   assign fsm_state = state;

   bcd_shift_step u_step (
      .bcd_in  (bcd_r),
      .bin_in  (bin_r),
      .bcd_out (bcd_step),
      .bin_out (bin_step)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (load) state_nxt = ST_PREP;
         ST_PREP:   state_nxt = hex_r ? ST_FORMAT : ST_SHIFT;
         ST_SHIFT:  if (iter_r == 4'(SHIFT_ITERS - 1)) state_nxt = ST_FORMAT;
         ST_FORMAT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      neg_c = sgn_r & val_r[15];
      mag_c = neg_c ? (~val_r + 16'd1) : val_r;
      ovf_c = neg_c ? (mag_c > DEC_MAX_NEG) : (mag_c > DEC_MAX_POS);
   end

   // num3 is never blanked so zero still shows a single 0.
   always_comb begin
      lead = 1'b1;
      dig  = 4'd0;
      for (int i = 0; i < 4; i++) begin
         dig = bcd_r[15-4*i -: 4];
         if (hex_r) begin
            code[i] = {2'b00, val_r[15-4*i -: 4]};
         end else if (ovf_r) begin
            code[i] = CODE_DASH;
         end else if (BLANK_LEADING && lead && dig == 4'd0 && i != 3) begin
            code[i] = CODE_BLANK;
         end else begin
            code[i] = {2'b00, dig};
            lead    = 1'b0;
         end
      end
      if (!hex_r && !ovf_r && neg_r) begin
         if (!BLANK_LEADING) begin
            code[0] = CODE_DASH;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (code[i] == CODE_BLANK && code[i+1] != CODE_BLANK) code[i] = CODE_DASH;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         num0   <= CODE_BLANK;
         num1   <= CODE_BLANK;
         num2   <= CODE_BLANK;
         num3   <= CODE_BLANK;
         val_r  <= 16'd0;
         hex_r  <= 1'b0;
         sgn_r  <= 1'b0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
         bin_r  <= 14'd0;
         bcd_r  <= 16'd0;
         iter_r <= 4'd0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);
         done  <= (state == ST_FORMAT);
         case (state)
            ST_IDLE: begin
               if (load) begin
                  val_r <= value;
                  hex_r <= hex_mode;
                  sgn_r <= is_signed;
               end
            end
            ST_PREP: begin
               neg_r  <= neg_c;
               ovf_r  <= ovf_c;
               bin_r  <= mag_c[13:0];
               bcd_r  <= 16'd0;
               iter_r <= 4'd0;
            end
            ST_SHIFT: begin
               bcd_r  <= bcd_step;
               bin_r  <= bin_step;
               iter_r <= iter_r + 4'd1;
            end
            ST_FORMAT: begin
               num0 <= code[0];
               num1 <= code[1];
               num2 <= code[2];
               num3 <= code[3];
            end
            default: ;
         endcase
      end
   end
endmodule
